// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: FSM states and protocol byte codes.
package uart_bridge_pkg;

   // Bridge control states.
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      BUS,
      RESP
   } bridgeState_t;

   // Command opcodes and response codes.
   localparam logic [7:0] OP_READ  = 8'h52;
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;

   // True for the two opcodes the bridge understands.
   function automatic logic isOpcode(input logic [7:0] b);
      return (b == OP_READ) || (b == OP_WRITE);
   endfunction

endpackage

// File: rtl/uart_bridge_resp.sv
// Response serializer: loads a 1-byte or 5-byte response and hands it out
// one byte per txValid/txReady handshake, most significant byte first.
module uart_bridge_resp
   import uart_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        loadLong,
   input  logic [7:0]  firstByte,
   input  logic [31:0] word,
   input  logic        txReady,
   output logic [7:0]  txData,
   output logic        txValid,
   output logic        done
);

   logic [39:0] shiftReg;
   logic [2:0]  remainingReg;
   logic        accept;

   assign txValid = (remainingReg != 3'd0);
   assign txData  = shiftReg[39:32];
   assign accept  = txValid && txReady;
   // Pulses in the cycle the final byte is taken by the transmitter.
   assign done    = accept && (remainingReg == 3'd1);

   // Load a fresh response or advance to the next byte on each accepted handshake.
   // Short responses pad with zeros so txData returns to 0 once drained.
   always_ff @(posedge clk) begin
      if (reset) begin
         shiftReg     <= 40'h0;
         remainingReg <= 3'd0;
      end else if (load) begin
         shiftReg     <= {firstByte, (loadLong ? word : 32'h0)};
         remainingReg <= loadLong ? 3'd5 : 3'd1;
      end else if (accept) begin
         shiftReg     <= {shiftReg[31:0], 8'h00};
         remainingReg <= remainingReg - 3'd1;
      end
   end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command bridge: parses read/write frames from a byte stream, performs a
// single 32-bit bus access and returns ACK/NAK (plus read data) as bytes.
module uart_bus_bridge #(
   parameter int TimeoutCycles     = 100000,
   parameter int RespTimeoutCycles = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxValid,
   input  logic [7:0]  rxData,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic        ren,
   output logic        wen,
   output logic [3:0]  strobe,
   input  logic [31:0] rdata,
   input  logic        request_stall,
   input  logic        error
);

   import uart_bridge_pkg::*;

   // Counters are sized to hold their limit, so the terminal count is always reachable.
   localparam int IdleW  = $clog2(TimeoutCycles + 1);
   localparam int StallW = $clog2(RespTimeoutCycles + 1);
   localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TimeoutCycles - 1);
   localparam logic [StallW-1:0] StallLast = StallW'(RespTimeoutCycles - 1);

   bridgeState_t      stateReg;
   bridgeState_t      stateNext;
   logic              isWriteReg;
   logic [1:0]        byteCountReg;
   logic [IdleW-1:0]  idleCountReg;
   logic [StallW-1:0] stallCountReg;
   logic [31:0]       addrReg;
   logic [31:0]       wdataReg;
   logic              renReg;
   logic              wenReg;

   logic              busy;
   logic              idleExpired;
   logic              stallExpired;
   logic [31:0]       addrAssembled;
   logic              respLoad;
   logic              respLong;
   logic [7:0]        respFirst;
   logic              respDone;

   assign busy          = renReg | wenReg;
   assign idleExpired   = (idleCountReg == IdleLast);
   assign stallExpired  = (stallCountReg == StallLast);
   assign addrAssembled = {addrReg[23:0], rxData};

   assign addr   = addrReg;
   assign wdata  = wdataReg;
   assign ren    = renReg;
   assign wen    = wenReg;
   assign strobe = 4'hF;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   // Next-state decode and response selection.
   always_comb begin
      stateNext = stateReg;
      respLoad  = 1'b0;
      respLong  = 1'b0;
      respFirst = NAK;
      case (stateReg)
         IDLE: begin
            if (rxValid) begin
               if (isOpcode(rxData)) begin
                  stateNext = ADDR;
               end else begin
                  stateNext = RESP;
                  respLoad  = 1'b1;
               end
            end
         end
         ADDR: begin
            if (rxValid) begin
               if (byteCountReg == 2'd3) begin
                  if (addrAssembled[1:0] != 2'b00) begin
                     stateNext = RESP;
                     respLoad  = 1'b1;
                  end else if (isWriteReg) begin
                     stateNext = DATA;
                  end else begin
                     stateNext = BUS;
                  end
               end
            end else if (idleExpired) begin
               stateNext = IDLE;
            end
         end
         DATA: begin
            if (rxValid) begin
               if (byteCountReg == 2'd3) begin
                  stateNext = BUS;
               end
            end else if (idleExpired) begin
               stateNext = IDLE;
            end
         end
         BUS: begin
            // The first BUS cycle only raises the request; completion is judged once it is visible.
            if (busy) begin
               if (!request_stall) begin
                  stateNext = RESP;
                  respLoad  = 1'b1;
                  if (!error) begin
                     respFirst = ACK;
                     respLong  = !isWriteReg;
                  end
               end else if (stallExpired) begin
                  stateNext = RESP;
                  respLoad  = 1'b1;
               end
            end
         end
         RESP: begin
            if (respDone) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Frame capture, bus request and watchdog counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         isWriteReg    <= 1'b0;
         byteCountReg  <= 2'd0;
         idleCountReg  <= '0;
         stallCountReg <= '0;
         addrReg       <= 32'h0;
         wdataReg      <= 32'h0;
         renReg        <= 1'b0;
         wenReg        <= 1'b0;
      end else begin
         // Request is held for as long as the FSM stays in BUS and drops the cycle after it leaves.
         renReg <= (stateReg == BUS) && (stateNext == BUS) && !isWriteReg;
         wenReg <= (stateReg == BUS) && (stateNext == BUS) && isWriteReg;

         if ((stateReg == ADDR || stateReg == DATA) && !rxValid) begin
            idleCountReg <= idleCountReg + 1'b1;
         end else begin
            idleCountReg <= '0;
         end

         if ((stateReg == BUS) && busy && request_stall) begin
            stallCountReg <= stallCountReg + 1'b1;
         end else begin
            stallCountReg <= '0;
         end

         if (stateReg == IDLE) begin
            byteCountReg <= 2'd0;
            if (rxValid) begin
               isWriteReg <= (rxData == OP_WRITE);
            end
         end

         // The 2-bit byte counter wraps from 3 to 0, which restarts it for the data phase.
         if ((stateReg == ADDR || stateReg == DATA) && rxValid) begin
            byteCountReg <= byteCountReg + 2'd1;
         end

         if ((stateReg == ADDR) && rxValid) begin
            addrReg <= addrAssembled;
         end

         if ((stateReg == DATA) && rxValid) begin
            wdataReg <= {wdataReg[23:0], rxData};
         end
      end
   end

   uart_bridge_resp respUnit (
      .clk       (clk),
      .reset     (reset),
      .load      (respLoad),
      .loadLong  (respLong),
      .firstByte (respFirst),
      .word      (rdata),
      .txReady   (txReady),
      .txData    (txData),
      .txValid   (txValid),
      .done      (respDone)
   );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed vector table, corner-case
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_bus_bridge;

   localparam int TO  = 40;
   localparam int RTO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rxValid = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ren;
   logic        wen;
   logic [3:0]  strobe;
   logic [31:0] rdata;
   logic        request_stall;
   logic        error;

   always #5 clk = ~clk;

   uart_bus_bridge #(.TimeoutCycles(TO), .RespTimeoutCycles(RTO)) dut (
      .clk           (clk),
      .reset         (reset),
      .rxValid       (rxValid),
      .rxData        (rxData),
      .txData        (txData),
      .txValid       (txValid),
      .txReady       (txReady),
      .addr          (addr),
      .wdata         (wdata),
      .ren           (ren),
      .wen           (wen),
      .strobe        (strobe),
      .rdata         (rdata),
      .request_stall (request_stall),
      .error         (error)
   );

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      int          stall;
      bit          err;
      logic [31:0] rd;
      int          expKind;     // 0 none, 1 read, 2 write
      int          expCycles;   // cycles the request is high
      logic [39:0] expTx;       // response bytes, first byte in the top lane
      int          expTxLen;
   } vec_t;

   int nChecks = 0;
   int nPass   = 0;

   // Bus responder and transmitter scoreboards.
   int          readyMode = 0;  // 0 always ready, 1 random, 2 never
   int          cfgStall = 0;
   bit          cfgError = 1'b0;
   logic [31:0] cfgRdata = 32'h0;
   int          accCount = 0;
   int          accKind = 0;
   int          accCycles = 0;
   logic [31:0] accAddr = 32'h0;
   logic [31:0] accWdata = 32'h0;
   bit          inAccess = 1'b0;
   logic [7:0]  txLog[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bus responder: stalls the first cfgStall request cycles, then completes.
   initial begin
      request_stall = 1'b0;
      error = 1'b0;
      rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (ren || wen) begin
            check("bus_exclusive", 64'(ren && wen), 64'd0);
            check("bus_strobe", 64'(strobe), 64'hF);
            if (!inAccess) begin
               inAccess = 1'b1;
               accCount++;
               accKind = wen ? 2 : 1;
               accAddr = addr;
               accWdata = wdata;
               accCycles = 0;
            end else begin
               check("bus_addr_stable", 64'(addr), 64'(accAddr));
               check("bus_wdata_stable", 64'(wdata), 64'(accWdata));
            end
            accCycles++;
            request_stall = (accCycles <= cfgStall);
            error = cfgError && !request_stall;
            rdata = request_stall ? $urandom : cfgRdata;
         end else begin
            inAccess = 1'b0;
            request_stall = 1'($urandom_range(0, 1));
            error = 1'($urandom_range(0, 1));
            rdata = $urandom;
         end
      end
   end

   // Transmit sink: applies the ready policy, logs accepted bytes, checks hold while stalled.
   initial begin
      bit         pending;
      logic [7:0] heldData;
      pending = 1'b0;
      heldData = 8'h00;
      txReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (pending) begin
            check("tx_hold_valid", 64'(txValid), 64'd1);
            check("tx_hold_data", 64'(txData), 64'(heldData));
         end
         case (readyMode)
            0: txReady = 1'b1;
            1: txReady = ($urandom_range(0, 9) < 7);
            default: txReady = 1'b0;
         endcase
         if (txValid && txReady) txLog.push_back(txData);
         pending = txValid && !txReady;
         heldData = txData;
      end
   end

   // Reference model: expected bus activity and response from the frame contents alone.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      r = v;
      r.expKind = 0;
      r.expCycles = 0;
      r.expTx = {8'h15, 32'h0};
      r.expTxLen = 1;
      if ((v.op == 8'h52 || v.op == 8'h57) && v.a[1:0] == 2'b00) begin
         r.expKind = (v.op == 8'h57) ? 2 : 1;
         if (v.stall >= RTO) begin
            r.expCycles = RTO;
         end else begin
            r.expCycles = v.stall + 1;
            if (!v.err) begin
               r.expTx = {8'h06, (v.op == 8'h52) ? v.rd : 32'h0};
               r.expTxLen = (v.op == 8'h52) ? 5 : 1;
            end
         end
      end
      return r;
   endfunction

   // Bytes actually sent: a rejected opcode or misaligned address ends the frame early.
   function automatic int frameLen(input vec_t v);
      if (v.op != 8'h52 && v.op != 8'h57) return 1;
      if (v.a[1:0] != 2'b00) return 5;
      return (v.op == 8'h52) ? 5 : 9;
   endfunction

   task automatic sendByte(input logic [7:0] b, input int gap);
      rxValid = 1'b1;
      rxData = b;
      tick(1);
      rxValid = 1'b0;
      tick(gap);
   endtask

   task automatic sendFrame(input vec_t v, input int maxGap);
      logic [71:0] fb;
      fb = {v.op, v.a, v.d};
      cfgStall = v.stall;
      cfgError = v.err;
      cfgRdata = v.rd;
      for (int i = 0; i < frameLen(v); i++) begin
         sendByte(fb[71 - 8*i -: 8], $urandom_range(0, maxGap));
      end
   endtask

   task automatic waitQuiet(input int txBase, input int expLen);
      bit quiet;
      quiet = 1'b0;
      for (int b = 0; b < 400 && !quiet; b++) begin
         if (txLog.size() - txBase >= expLen && !txValid && !ren && !wen) quiet = 1'b1;
         else tick(1);
      end
      check("resp_complete", 64'(quiet), 64'd1);
      tick(4);
   endtask

   task automatic checkResult(input vec_t v, input int base, input int txBase);
      check("bus_count", 64'(accCount - base), 64'(v.expKind != 0));
      if (v.expKind != 0 && accCount - base == 1) begin
         check("bus_kind", 64'(accKind), 64'(v.expKind));
         check("bus_addr", 64'(accAddr), 64'(v.a));
         check("bus_cycles", 64'(accCycles), 64'(v.expCycles));
         if (v.expKind == 2) check("bus_wdata", 64'(accWdata), 64'(v.d));
      end
      check("tx_len", 64'(txLog.size() - txBase), 64'(v.expTxLen));
      for (int i = 0; i < v.expTxLen && txBase + i < txLog.size(); i++) begin
         check("tx_byte", 64'(txLog[txBase + i]), 64'(v.expTx[39 - 8*i -: 8]));
      end
   endtask

   task automatic runVec(input vec_t v, input int maxGap);
      int base;
      int txBase;
      base = accCount;
      txBase = txLog.size();
      sendFrame(v, maxGap);
      waitQuiet(txBase, v.expTxLen);
      checkResult(v, base, txBase);
      $display("txn op=%02h addr=%08h stall=%0d err=%0d -> bus=%0d cycles=%0d tx=%0d bytes",
               v.op, v.a, v.stall, v.err, accCount - base, accCycles, txLog.size() - txBase);
   endtask

   initial begin
      vec_t dir[9];
      vec_t v;
      int   base;
      int   txBase;
      bit   seen;

      dir[0] = '{op:8'h52, a:32'h0000_1000, d:32'h0, stall:2, err:1'b0, rd:32'hDEAD_BEEF,
                 expKind:1, expCycles:3, expTx:40'h06_DEAD_BEEF, expTxLen:5};
      dir[1] = '{op:8'h57, a:32'h0000_0008, d:32'hCAFE_BABE, stall:0, err:1'b0, rd:32'h0,
                 expKind:2, expCycles:1, expTx:40'h06_0000_0000, expTxLen:1};
      dir[2] = '{op:8'h41, a:32'h0, d:32'h0, stall:0, err:1'b0, rd:32'h0,
                 expKind:0, expCycles:0, expTx:40'h15_0000_0000, expTxLen:1};
      dir[3] = '{op:8'h52, a:32'h0000_0000, d:32'h0, stall:0, err:1'b0, rd:32'h1234_5678,
                 expKind:1, expCycles:1, expTx:40'h06_1234_5678, expTxLen:5};
      dir[4] = '{op:8'h52, a:32'h0000_0002, d:32'h0, stall:0, err:1'b0, rd:32'h0,
                 expKind:0, expCycles:0, expTx:40'h15_0000_0000, expTxLen:1};
      dir[5] = '{op:8'h52, a:32'h0000_0004, d:32'h0, stall:1, err:1'b1, rd:32'h5555_AAAA,
                 expKind:1, expCycles:2, expTx:40'h15_0000_0000, expTxLen:1};
      dir[6] = '{op:8'h52, a:32'h0000_0020, d:32'h0, stall:16, err:1'b0, rd:32'h7777_7777,
                 expKind:1, expCycles:16, expTx:40'h15_0000_0000, expTxLen:1};
      dir[7] = '{op:8'h57, a:32'h0000_0040, d:32'h1122_3344, stall:15, err:1'b0, rd:32'h0,
                 expKind:2, expCycles:16, expTx:40'h06_0000_0000, expTxLen:1};
      dir[8] = '{op:8'h57, a:32'h0000_0103, d:32'h9999_9999, stall:0, err:1'b0, rd:32'h0,
                 expKind:0, expCycles:0, expTx:40'h15_0000_0000, expTxLen:1};

      // Reset state.
      tick(3);
      check("rst_ren", 64'(ren), 64'd0);
      check("rst_wen", 64'(wen), 64'd0);
      check("rst_txvalid", 64'(txValid), 64'd0);
      check("rst_txdata", 64'(txData), 64'd0);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_wdata", 64'(wdata), 64'd0);
      reset = 1'b0;
      tick(2);
      check("idle_ren", 64'(ren | wen), 64'd0);
      check("idle_txvalid", 64'(txValid), 64'd0);

      // Directed vector table.
      for (int i = 0; i < 9; i++) runVec(dir[i], 0);

      // Inter-byte timeout discards a partial frame silently.
      base = accCount;
      txBase = txLog.size();
      sendByte(8'h52, 0);
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
      tick(TO + 1);
      check("timeout_no_bus", 64'(accCount - base), 64'd0);
      check("timeout_no_tx", 64'(txLog.size() - txBase), 64'd0);
      check("timeout_txvalid", 64'(txValid), 64'd0);
      runVec(dir[0], 0);

      // Transmitter back-pressure for 20 cycles during a read response.
      v = '{op:8'h52, a:32'h0000_0100, d:32'h0, stall:0, err:1'b0, rd:32'hA5A5_5A5A,
            expKind:1, expCycles:1, expTx:40'h06_A5A5_5A5A, expTxLen:5};
      readyMode = 2;
      base = accCount;
      txBase = txLog.size();
      sendFrame(v, 0);
      seen = 1'b0;
      for (int b = 0; b < 50 && !seen; b++) begin
         if (txValid) seen = 1'b1;
         else tick(1);
      end
      check("bp_txvalid_seen", 64'(seen), 64'd1);
      tick(20);
      check("bp_still_valid", 64'(txValid), 64'd1);
      check("bp_nothing_taken", 64'(txLog.size() - txBase), 64'd0);
      readyMode = 0;
      waitQuiet(txBase, v.expTxLen);
      checkResult(v, base, txBase);

      // Reset during a stalled bus access.
      v = '{op:8'h52, a:32'h0000_0200, d:32'h0, stall:10, err:1'b0, rd:32'h0,
            expKind:1, expCycles:0, expTx:40'h0, expTxLen:0};
      txBase = txLog.size();
      sendFrame(v, 0);
      seen = 1'b0;
      for (int b = 0; b < 20 && !seen; b++) begin
         if (ren) seen = 1'b1;
         else tick(1);
      end
      check("rstbus_ren_seen", 64'(seen), 64'd1);
      tick(2);
      reset = 1'b1;
      tick(1);
      check("rstbus_ren", 64'(ren), 64'd0);
      check("rstbus_wen", 64'(wen), 64'd0);
      check("rstbus_txvalid", 64'(txValid), 64'd0);
      reset = 1'b0;
      tick(15);
      check("rstbus_no_tx", 64'(txLog.size() - txBase), 64'd0);
      check("rstbus_ren_idle", 64'(ren), 64'd0);
      runVec(dir[3], 0);

      // Randomized frames against the reference model.
      readyMode = 1;
      for (int n = 0; n < 40; n++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 4) v.op = 8'h52;
         else if (sel < 8) v.op = 8'h57;
         else begin
            v.op = 8'($urandom);
            if (v.op == 8'h52 || v.op == 8'h57) v.op = 8'h00;
         end
         v.a = $urandom;
         if ($urandom_range(0, 3) != 0) v.a[1:0] = 2'b00;
         v.d = $urandom;
         v.stall = $urandom_range(0, 20);
         v.err = ($urandom_range(0, 4) == 0);
         v.rd = $urandom;
         v = model(v);
         runVec(v, 3);
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
